stopwatch_ctrl: RTL
===================

// Module: stopwatch_ctrl
// PURPOSE
//  Stopwatch sequencer for the Basys3 top level. Takes the raw START and LAP push-buttons,
//  runs an SS.hh BCD time counter (00.00..99.99 s) and drives the 16-bit DATA/EN inputs
//  of the 4-digit 7-segment interface. The display DP sits on digit 2, giving "SS.hh".
//  Supports run/stop, lap-hold (display frozen, count continues) and clear.
// PARAMETERS
//  TICK_DIV  1_000_000  CLK cycles per 1/100 s tick (100 MHz -> 10 ms)
//  DEB_CNT   1_000_000  cycles a synchronized button level must be stable to be accepted
// PORTS
//  CLK        in   1   system clock, 100 MHz; the only clock
//  XRST       in   1   reset, asynchronous, active-high
//  BTN_START  in   1   raw start/stop button, asynchronous, active-high
//  BTN_LAP    in   1   raw lap/clear button, asynchronous, active-high
//  DATA       out  16  BCD digits to display: [15:12]=s tens, [11:8]=s ones, [7:4]=1/10, [3:0]=1/100
//  EN         out  1   display enable; 0 in reset, 1 from first clock after reset release
//  RUNNING    out  1   1 in RUN and LAP_HOLD
//  OVF        out  1   one-cycle pulse when count wraps 99.99 -> 00.00
// BEHAVIOUR
//  Reset (async, any time, incl. mid-count): state=IDLE, time=0000, lap=0000, divider=0,
//   DATA=16'h0000, EN=0, RUNNING=0, OVF=0, debouncers cleared (stable level 0, no pulse).
//  Buttons: 2-FF synchronizer -> debounce (level accepted after DEB_CNT stable cycles)
//   -> rising-edge detect -> 1-cycle press pulse. Held button yields exactly one pulse.
//  Both pulses in same cycle: START acts, LAP dropped.
//  FSM (transitions on press pulses; unlisted pulses ignored):
//   IDLE     : START -> RUN
//   RUN      : START -> STOP;     LAP -> LAP_HOLD (lap <= time at that cycle)
//   LAP_HOLD : LAP   -> RUN;      START -> STOP
//   STOP     : START -> RUN;      LAP -> IDLE (time, lap, divider <= 0)
//  Divider: counts 0..TICK_DIV-1 only in RUN/LAP_HOLD; tick = (div==TICK_DIV-1), div wraps to 0.
//   Held (not cleared) in STOP so resume keeps sub-tick phase; cleared on entering IDLE.
//  Time counter: 4 BCD digits, each 0..9, ripple carry on tick; only legal BCD ever stored.
//   9999 + tick -> 0000, OVF=1 for that same cycle as the wrap write; counting continues.
//  DATA source: lap register in LAP_HOLD, live time otherwise. DATA is registered:
//   updates exactly 1 CLK after the time/lap register changes (state change also 1 CLK).
//  RUNNING registered with the state (same cycle as state).
// STRUCTURE
//  Shared header stopwatch_defs.vh: state encodings (IDLE=2'd0, RUN=2'd1, LAP_HOLD=2'd2,
//   STOP=2'd3), BCD digit width (4), digit max (4'd9).
//  Sub-module btn_pulse (param DEB_CNT): sync + debounce + edge pulse; instantiated twice.
//  Top: FSM, tick divider, 4-digit BCD counter, lap register, DATA/EN output registers.
// TESTING (bench uses TICK_DIV=4, DEB_CNT=2)
//  Reset: XRST=1 mid-RUN at 12.34 -> next edge-independent DATA=0000, EN=0, state IDLE;
//   release -> EN=1 one CLK later, DATA stays 0000.
//  Start/count: press START (held 10 cycles) -> one pulse, RUN; after 40 CLK DATA=0010;
//   after 400 CLK DATA=0100; release/re-press of held button produces no extra pulse.
//  Stop/resume/clear: RUN at 0005, START -> DATA frozen 0005 for 100 CLK; START -> resumes
//   with no lost sub-tick; STOP then LAP -> IDLE, DATA=0000.
//  Lap: RUN at 0150, LAP -> DATA holds 0150 while internal time advances; LAP after 80 CLK
//   -> DATA shows live 0170.
//  Wrap: preload time 9998 (force), run 8 CLK -> DATA 9999 then 0000, OVF high exactly 1 CLK.
//  Simultaneous: START and LAP pulses same cycle in RUN -> STOP, lap register unchanged.
//  Bounce: toggle BTN_START every cycle for 20 cycles then settle high -> exactly one pulse.

Source files
------------

// File: rtl/stopwatch_ctrl_pkg.sv
// Shared types and helpers for the SS.hh stopwatch: FSM states, BCD time word
// and the BCD increment used by the time counter.
package stopwatch_ctrl_pkg;

   localparam int DIGIT_W    = 4;
   localparam int NUM_DIGITS = 4;
   localparam logic [DIGIT_W-1:0] DIGIT_MAX = 4'd9;

   typedef enum logic [1:0] {
      ST_IDLE     = 2'd0,
      ST_RUN      = 2'd1,
      ST_LAP_HOLD = 2'd2,
      ST_STOP     = 2'd3
   } state_t;

   // Digit 3 = seconds tens ... digit 0 = hundredths.
   typedef logic [NUM_DIGITS-1:0][DIGIT_W-1:0] bcd_time_t;

   function automatic logic bcd_is_max(input bcd_time_t t);
      logic m;
      m = 1'b1;
      for (int i = 0; i < NUM_DIGITS; i++) begin
         m = m & (t[i] == DIGIT_MAX);
      end
      return m;
   endfunction

   function automatic bcd_time_t bcd_inc(input bcd_time_t t);
      bcd_time_t r;
      logic      carry;
      // NOTE: blocking assignments are right here; this is pure combinational evaluation.
      r     = t;
      carry = 1'b1;
      for (int i = 0; i < NUM_DIGITS; i++) begin
         if (carry) begin
            if (t[i] == DIGIT_MAX) begin
               r[i] = '0;
            end else begin
               r[i]  = t[i] + DIGIT_W'(1);
               carry = 1'b0;
            end
         end
      end
      return r;
   endfunction

endpackage

// File: rtl/stopwatch_ctrl_if.sv
// Button inputs and 7-segment display bus of the stopwatch.
// The master side is the controller; the slave side is the display/button board.
interface stopwatch_ctrl_if;
   import stopwatch_ctrl_pkg::*;

   logic      BTN_START;
   logic      BTN_LAP;
   bcd_time_t DATA;
   logic      EN;
   logic      RUNNING;
   logic      OVF;

   modport master (input BTN_START, BTN_LAP, output DATA, EN, RUNNING, OVF);
   modport slave  (output BTN_START, BTN_LAP, input DATA, EN, RUNNING, OVF);
endinterface

// File: rtl/stopwatch_ctrl_btn_pulse.sv
// Raw push-button to one-cycle press pulse: 2-FF synchronizer, stable-level
// debounce (DEB_CNT cycles), rising-edge pulse on the accepted level.
module stopwatch_ctrl_btn_pulse #(
   parameter int DEB_CNT = 1_000_000
) (
   input  logic CLK,
   input  logic XRST,
   input  logic BTN,
   output logic PULSE
);
   localparam int CNT_W = (DEB_CNT > 1) ? $clog2(DEB_CNT) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEB_CNT - 1);

   logic [1:0]       sync_q;
   logic             level_q;
   logic [CNT_W-1:0] cnt_q;

   always_ff @(posedge CLK or posedge XRST) begin
      if (XRST) begin
         sync_q  <= 2'b00;
         level_q <= 1'b0;
         cnt_q   <= '0;
         PULSE   <= 1'b0;
      end else begin
         // NOTE: non-blocking keeps the two synchronizer stages as two separate flops.
         sync_q <= {sync_q[0], BTN};
         PULSE  <= 1'b0;
         if (sync_q[1] == level_q) begin
            cnt_q <= '0;
         end else if (cnt_q == CNT_LAST) begin
            level_q <= sync_q[1];
            cnt_q   <= '0;
            PULSE   <= sync_q[1];
         end else begin
            cnt_q <= cnt_q + CNT_W'(1);
         end
      end
   end

endmodule

// File: rtl/stopwatch_ctrl.sv
// Stopwatch sequencer: run/stop/lap-hold/clear FSM, 1/100 s divider, SS.hh BCD
// counter, lap register and registered display outputs.
module stopwatch_ctrl import stopwatch_ctrl_pkg::*; #(
   parameter int TICK_DIV = 1_000_000,
   parameter int DEB_CNT  = 1_000_000
) (
   input logic               CLK,
   input logic               XRST,
   stopwatch_ctrl_if.master  sw
);
   localparam int DIV_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(TICK_DIV - 1);

   logic       start_p, lap_raw_p, lap_p;
   logic       counting, tick, capture, clear;
   state_t     state_q;
   logic       running_q;
   logic [DIV_W-1:0] div_q;
   bcd_time_t  time_q, lap_q, data_q;
   logic       en_q, ovf_q;

   stopwatch_ctrl_btn_pulse #(.DEB_CNT(DEB_CNT)) u_start (
      .CLK(CLK), .XRST(XRST), .BTN(sw.BTN_START), .PULSE(start_p)
   );
   stopwatch_ctrl_btn_pulse #(.DEB_CNT(DEB_CNT)) u_lap (
      .CLK(CLK), .XRST(XRST), .BTN(sw.BTN_LAP), .PULSE(lap_raw_p)
   );

   // START wins a same-cycle collision; the LAP press is simply dropped.
   assign lap_p    = lap_raw_p & ~start_p;
   assign counting = (state_q == ST_RUN) || (state_q == ST_LAP_HOLD);
   assign tick     = counting && (div_q == DIV_LAST);
   assign capture  = (state_q == ST_RUN) && lap_p;
   assign clear    = (state_q == ST_STOP) && lap_p;

   always_ff @(posedge CLK or posedge XRST) begin
      if (XRST) begin
         state_q   <= ST_IDLE;
         running_q <= 1'b0;
      end else begin
         case (state_q)
            ST_IDLE: if (start_p) begin
               state_q   <= ST_RUN;
               running_q <= 1'b1;
            end
            ST_RUN, ST_LAP_HOLD: if (start_p) begin
               state_q   <= ST_STOP;
               running_q <= 1'b0;
            end else if (lap_p) begin
               state_q <= (state_q == ST_RUN) ? ST_LAP_HOLD : ST_RUN;
            end
            ST_STOP: if (start_p) begin
               state_q   <= ST_RUN;
               running_q <= 1'b1;
            end else if (lap_p) begin
               state_q <= ST_IDLE;
            end
            default: begin
               state_q   <= ST_IDLE;
               running_q <= 1'b0;
            end
         endcase
      end
   end

   // Divider is held in STOP so a resume keeps its sub-tick phase.
   always_ff @(posedge CLK or posedge XRST) begin
      if (XRST) begin
         div_q  <= '0;
         time_q <= '0;
         lap_q  <= '0;
         data_q <= '0;
         en_q   <= 1'b0;
         ovf_q  <= 1'b0;
      end else begin
         en_q   <= 1'b1;
         ovf_q  <= tick && bcd_is_max(time_q);
         data_q <= (state_q == ST_LAP_HOLD) ? lap_q : time_q;
         if (clear) begin
            div_q  <= '0;
            time_q <= '0;
            lap_q  <= '0;
         end else begin
            if (capture) lap_q <= time_q;
            if (tick) begin
               div_q  <= '0;
               time_q <= bcd_inc(time_q);
            end else if (counting) begin
               div_q <= div_q + DIV_W'(1);
            end
         end
      end
   end

   assign sw.DATA    = data_q;
   assign sw.EN      = en_q;
   assign sw.RUNNING = running_q;
   assign sw.OVF     = ovf_q;

endmodule
